// File: rtl/tape_pkg.sv
// Shared types and helpers for the cassette-output audio path.
package tape_pkg;

  typedef logic signed [15:0] pcm_t;

  typedef enum logic {TP_IDLE = 1'b0, TP_ACTIVE = 1'b1} tape_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/tape_slew.sv
// Ramp limiter: on each sample strobe moves the level toward the target by at
// most RAMP_STEP, so every level change is click-free.
module tape_slew
  import tape_pkg::*;
#(
  parameter logic [15:0] RAMP_STEP = 16'd64
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sample_ce,
  input  pcm_t target,
  output pcm_t level
);

  logic signed [16:0] w_step;
  logic signed [16:0] w_cur;
  logic signed [16:0] w_tgt;
  logic signed [16:0] w_diff;
  pcm_t               w_next;
  pcm_t               r_level;

  assign w_step = $signed({1'b0, RAMP_STEP});
  assign w_cur  = {r_level[15], r_level};
  assign w_tgt  = {target[15], target};
  assign w_diff = w_tgt - w_cur;

  // The stepped value always lies between level and target, so 16 bits hold it.
  always_comb begin
    w_next = target;
    if (w_diff > w_step) begin
      w_next = pcm_t'(w_cur + w_step);
    end else if (w_diff < -w_step) begin
      w_next = pcm_t'(w_cur - w_step);
    end else begin
      w_next = target;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_level <= 16'sd0;
    end else if (sample_ce) begin
      r_level <= w_next;
    end else begin
      r_level <= r_level;
    end
  end

  assign level = r_level;

endmodule

// File: rtl/tape_out_audio.sv
// K7 tape-output modulator: activity FSM with timeout, ramped +/-AMPL audio.
// Define TAPE_OUT_PERIOD_EN to build the rising-edge period monitor.
module tape_out_audio
  import tape_pkg::*;
#(
  parameter int          CLK_HZ     = 24000000,
  parameter logic [15:0] AMPL       = 16'h2000,
  parameter logic [15:0] RAMP_STEP  = 16'd64,
  parameter int          TIMEOUT_MS = 500,
  parameter int          PERIOD_W   = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                tape_out,
  input  logic                sample_ce,
  input  logic                mute,
  output pcm_t                audio,
  output logic                active,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  localparam int TO_CYC = ms_to_cycles(CLK_HZ, TIMEOUT_MS);
  localparam int TO_W   = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  tape_state_t     r_state;
  tape_state_t     w_next_state;
  logic            r_tape_q;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_edge;
  logic            w_term;
  pcm_t            w_target;
  pcm_t            w_level;
  pcm_t            r_audio;

  assign w_edge = tape_out ^ r_tape_q;
  assign w_term = (r_state == TP_ACTIVE) && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_tape_q <= 1'b0;
      r_state  <= TP_IDLE;
    end else begin
      r_tape_q <= tape_out;
      r_state  <= w_next_state;
    end
  end

  // A toggle on the terminal-count cycle keeps the FSM active.
  always_comb begin
    w_next_state = r_state;
    w_target     = 16'sd0;
    case (r_state)
      TP_IDLE: begin
        if (w_edge) w_next_state = TP_ACTIVE;
        else        w_next_state = TP_IDLE;
      end
      TP_ACTIVE: begin
        if (w_edge)      w_next_state = TP_ACTIVE;
        else if (w_term) w_next_state = TP_IDLE;
        else             w_next_state = TP_ACTIVE;
        w_target = r_tape_q ? pcm_t'(AMPL) : pcm_t'(16'd0 - AMPL);
      end
      default: begin
        w_next_state = TP_IDLE;
        w_target     = 16'sd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_edge || (w_next_state == TP_IDLE)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  tape_slew #(
    .RAMP_STEP (RAMP_STEP)
  ) u_slew (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .sample_ce (sample_ce),
    .target    (w_target),
    .level     (w_level)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)     r_audio <= 16'sd0;
    else if (mute) r_audio <= 16'sd0;
    else           r_audio <= w_level;
  end

  assign audio  = r_audio;
  assign active = (r_state == TP_ACTIVE);

`ifdef TAPE_OUT_PERIOD_EN
  logic                w_rise;
  logic                r_seen;
  logic                r_period_valid;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [PERIOD_W-1:0] r_period;

  assign w_rise = tape_out & ~r_tape_q;

  // The first rise after entering ACTIVE only arms the measurement.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_seen         <= 1'b0;
      r_period_valid <= 1'b0;
      r_per_cnt      <= '0;
      r_period       <= '0;
    end else begin
      r_period_valid <= w_rise && r_seen;
      if (w_rise && r_seen) r_period <= r_per_cnt;
      if (w_next_state == TP_IDLE) begin
        r_seen    <= 1'b0;
        r_per_cnt <= '0;
      end else if (w_rise) begin
        r_seen    <= 1'b1;
        r_per_cnt <= PERIOD_W'(1);
      end else if (r_per_cnt != {PERIOD_W{1'b1}}) begin
        r_per_cnt <= r_per_cnt + PERIOD_W'(1);
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
